multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequencing controller for the multicycle RV32I datapath. It steps a shared ALU, a unified instruction/data memory port, the register file and the PC/IR registers through fetch, decode and execute phases, one state per cycle. It stalls on a memory-ready handshake and counts retired instructions. It sits beside the datapath in the CPU top and drives every datapath mux select and write enable.

## Interface
Parameters:
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode_i`  in  7  instruction-register bits [6:0].
- `funct3_i`  in  3  instruction-register bits [14:12].
- `zero_i`  in  1  ALU zero flag, combinational from the datapath.
- `mem_ready_i`  in  1  memory has completed the current access this cycle.
- `PCWrite_o`  out  1  load PC.
- `AdrSrc_o`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead_o`  out  1  memory read request.
- `MemWrite_o`  out  1  memory write request.
- `IRWrite_o`  out  1  load IR and OldPC.
- `ResultSrc_o`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA_o`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB_o`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ALUOp_o`  out  2  ALU op class: 00 = add, 01 = subtract, 10 = funct-decoded.
- `ImmSrc_o`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `RegWrite_o`  out  1  register-file write enable.
- `illegal_o`  out  1  high while in TRAP.
- `state_o`  out  4  current state encoding, for debug.
- `instret_o`  out  `INSTRET_W`  retired-instruction count.

## Operation
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, TRAP = 15.
- Outputs are a Moore decode of state. Exceptions are PCWrite_o and IRWrite_o, which also depend on `zero_i`, `funct3_i` and `mem_ready_i`.
- Any output not listed for a state is 0. ImmSrc_o is decoded from `opcode_i` in every state: lw/I-ALU = 00, sw = 01, branch = 10, jal = 11, other = 00.

Per-state behaviour:
- FETCH:
  - Outputs: AdrSrc = 0, MemRead = 1, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10. IRWrite = PCWrite = `mem_ready_i`.
  - Next state: DECODE if `mem_ready_i`, else stay in FETCH.
- DECODE:
  - Outputs: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch target into ALUOut).
  - Next state by `opcode_i`: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH if funct3 is 000 or 001, else TRAP; 1101111 → JAL; anything else → TRAP.
- MEMADR:
  - Outputs: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00.
  - Next state: MEMREAD if the opcode is a load, else MEMWRITE.
- MEMREAD:
  - Outputs: AdrSrc = 1, MemRead = 1.
  - Next state: MEMWB on `mem_ready_i`, else stay.
- MEMWB:
  - Outputs: ResultSrc = 01, RegWrite = 1.
  - Next state: FETCH; instruction retires.
- MEMWRITE:
  - Outputs: AdrSrc = 1, MemWrite = 1, held until `mem_ready_i`.
  - Next state: FETCH on `mem_ready_i`; instruction retires.
- EXECR:
  - Outputs: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10.
  - Next state: ALUWB.
- EXECI:
  - Outputs: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: ResultSrc = 00, RegWrite = 1.
  - Next state: FETCH; instruction retires.
- BRANCH:
  - Outputs: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00.
  - PCWrite = `zero_i` XOR `funct3_i[0]`, so beq takes the branch on zero and bne on non-zero.
  - Next state: FETCH; instruction retires whether or not the branch is taken.
- JAL:
  - Outputs: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1 (PC ← ALUOut target; ALUResult = OldPC + 4).
  - Next state: ALUWB.
- TRAP:
  - Outputs: illegal_o = 1; all enables 0.
  - Next state: stays in TRAP until `rst`.

Retired-instruction counter:
- `instret_o` increments by 1 on each retiring transition into FETCH.
- It wraps modulo 2^INSTRET_W.
- It does not count in TRAP.

## Timing
- Reset: while `rst` is high, state = FETCH, `instret_o` = 0 and all outputs are 0, including MemRead and IRWrite.
- FETCH decode resumes on the first rising edge after `rst` deasserts. Reset asserted mid-instruction aborts it immediately, with no register or memory write.
- Minimum cycles per instruction, with `mem_ready_i` held at 1: lw 5, sw 4, R-type 4, I-ALU 4, branch 3, jal 4.
- Each low cycle of `mem_ready_i` in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Request outputs stay stable throughout the stall.
- `mem_ready_i` is ignored in every other state.
- PCWrite_o in BRANCH is combinational from `zero_i` in the same cycle.

## Test plan
- Reset release with `mem_ready_i` = 1 and an R-type opcode (0110011): state sequence 0,1,6,8,0; RegWrite = 1 only in cycle 4; `instret_o` = 1.
- lw (0000011) with `mem_ready_i` low for 2 cycles in FETCH and 1 cycle in MEMREAD: total 8 cycles; AdrSrc = 1 and MemRead = 1 held across the stall; IRWrite pulses once.
- beq (funct3 = 000): with `zero_i` = 1, PCWrite = 1 in BRANCH. Same instruction with `zero_i` = 0 gives PCWrite = 0. bne (funct3 = 001) gives the inverse in both cases.
- Opcode 1111111, or a branch with funct3 = 100: DECODE → TRAP; illegal_o = 1 is held for 20 cycles; `instret_o` is frozen; `rst` returns the FSM to FETCH.
- `rst` asserted during MEMWRITE with `mem_ready_i` = 0: MemWrite drops to 0 asynchronously, the next state is FETCH and `instret_o` = 0.
- INSTRET_W = 4, 17 back-to-back jal instructions: `instret_o` wraps to 1; PCWrite = 1 in every JAL state; RegWrite = 1 in every following ALUWB.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32I sequencing controller
// Two-process FSM: registered state/instret, combinational Moore decode plus handshake-qualified enables.
module multicycle_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic                 PCWrite_o,
  output logic                 AdrSrc_o,
  output logic                 MemRead_o,
  output logic                 MemWrite_o,
  output logic                 IRWrite_o,
  output logic [1:0]           ResultSrc_o,
  output logic [1:0]           ALUSrcA_o,
  output logic [1:0]           ALUSrcB_o,
  output logic [1:0]           ALUOp_o,
  output logic [1:0]           ImmSrc_o,
  output logic                 RegWrite_o,
  output logic                 illegal_o,
  output logic [3:0]           state_o,
  output logic [INSTRET_W-1:0] instret_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t state;
  state_t next;
  logic   retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      instret_o <= '0;
    end else begin
      state <= next;
      if (retire) instret_o <= instret_o + INSTRET_W'(1);
    end
  end

  always_comb begin
    next        = state;
    retire      = 1'b0;
    PCWrite_o   = 1'b0;
    AdrSrc_o    = 1'b0;
    MemRead_o   = 1'b0;
    MemWrite_o  = 1'b0;
    IRWrite_o   = 1'b0;
    ResultSrc_o = 2'b00;
    ALUSrcA_o   = 2'b00;
    ALUSrcB_o   = 2'b00;
    ALUOp_o     = 2'b00;
    ImmSrc_o    = 2'b00;
    RegWrite_o  = 1'b0;
    illegal_o   = 1'b0;
    state_o     = state;

    case (opcode_i)
      OP_STORE:  ImmSrc_o = 2'b01;
      OP_BRANCH: ImmSrc_o = 2'b10;
      OP_JAL:    ImmSrc_o = 2'b11;
      default:   ImmSrc_o = 2'b00;
    endcase

    case (state)
      S_FETCH: begin
        MemRead_o   = 1'b1;
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        IRWrite_o   = mem_ready_i;
        PCWrite_o   = mem_ready_i;
        if (mem_ready_i) next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
        case (opcode_i)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_RTYPE:          next = S_EXECR;
          OP_ITYPE:          next = S_EXECI;
          OP_BRANCH:         next = (funct3_i[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            next = S_JAL;
          default:           next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        next      = (opcode_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc_o  = 1'b1;
        MemRead_o = 1'b1;
        if (mem_ready_i) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        RegWrite_o  = 1'b1;
        next        = S_FETCH;
        retire      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc_o   = 1'b1;
        MemWrite_o = 1'b1;
        if (mem_ready_i) begin
          next   = S_FETCH;
          retire = 1'b1;
        end
      end
      S_EXECR: begin
        ALUSrcA_o = 2'b10;
        ALUOp_o   = 2'b10;
        next      = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        ALUOp_o   = 2'b10;
        next      = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite_o = 1'b1;
        next       = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o = 2'b10;
        ALUOp_o   = 2'b01;
        // funct3[0] inverts the sense: beq takes on zero, bne on non-zero.
        PCWrite_o = zero_i ^ funct3_i[0];
        next      = S_FETCH;
        retire    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        PCWrite_o = 1'b1;
        next      = S_ALUWB;
      end
      S_TRAP: begin
        illegal_o = 1'b1;
        next      = S_TRAP;
      end
      default: next = S_TRAP;
    endcase

    // Reset forces every output quiet, including FETCH's read request.
    if (rst) begin
      PCWrite_o   = 1'b0;
      AdrSrc_o    = 1'b0;
      MemRead_o   = 1'b0;
      MemWrite_o  = 1'b0;
      IRWrite_o   = 1'b0;
      ResultSrc_o = 2'b00;
      ALUSrcA_o   = 2'b00;
      ALUSrcB_o   = 2'b00;
      ALUOp_o     = 2'b00;
      ImmSrc_o    = 2'b00;
      RegWrite_o  = 1'b0;
      illegal_o   = 1'b0;
      state_o     = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
// Queue-of-phases reference model, directed scenarios, then randomized instruction stream.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = RT;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic        p_pcw, p_adr, p_mr, p_mw, p_irw, p_rw, p_ill;
  logic [1:0]  p_rs, p_sa, p_sb, p_aop, p_imm;
  logic [3:0]  p_st;
  logic [31:0] p_ins;
  logic        q_pcw, q_adr, q_mr, q_mw, q_irw, q_rw, q_ill;
  logic [1:0]  q_rs, q_sa, q_sb, q_aop, q_imm;
  logic [3:0]  q_st;
  logic [3:0]  q_ins;

  multicycle_control_fsm #(.INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode), .funct3_i(funct3), .zero_i(zero),
    .mem_ready_i(mem_ready), .PCWrite_o(p_pcw), .AdrSrc_o(p_adr), .MemRead_o(p_mr),
    .MemWrite_o(p_mw), .IRWrite_o(p_irw), .ResultSrc_o(p_rs), .ALUSrcA_o(p_sa),
    .ALUSrcB_o(p_sb), .ALUOp_o(p_aop), .ImmSrc_o(p_imm), .RegWrite_o(p_rw),
    .illegal_o(p_ill), .state_o(p_st), .instret_o(p_ins));

  multicycle_control_fsm #(.INSTRET_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode_i(opcode), .funct3_i(funct3), .zero_i(zero),
    .mem_ready_i(mem_ready), .PCWrite_o(q_pcw), .AdrSrc_o(q_adr), .MemRead_o(q_mr),
    .MemWrite_o(q_mw), .IRWrite_o(q_irw), .ResultSrc_o(q_rs), .ALUSrcA_o(q_sa),
    .ALUSrcB_o(q_sb), .ALUOp_o(q_aop), .ImmSrc_o(q_imm), .RegWrite_o(q_rw),
    .illegal_o(q_ill), .state_o(q_st), .instret_o(q_ins));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining phase codes of the current instruction; empty means fetching.
  int          mq[$];
  logic [31:0] m_instret = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_instret = 0;
    end else if (mq.size() == 0) begin
      if (mem_ready) begin
        if (opcode == LW)      mq = '{1, 2, 3, 4};
        else if (opcode == SW) mq = '{1, 2, 5};
        else if (opcode == RT) mq = '{1, 6, 8};
        else if (opcode == IT) mq = '{1, 7, 8};
        else if (opcode == JL) mq = '{1, 10, 8};
        else if (opcode == BR && funct3 < 3'd2) mq = '{1, 9};
        else mq = '{1, 15};
      end
    end else if (mq[0] == 15) begin
    end else if ((mq[0] == 3 || mq[0] == 5) && !mem_ready) begin
    end else begin
      void'(mq.pop_front());
      if (mq.size() == 0) m_instret = m_instret + 1;
    end
  end

  function automatic logic [20:0] exp_vec(input int s, input logic [6:0] op, input logic [2:0] f3,
                                           input logic z, input logic r, input logic rs);
    logic pcw, adr, mr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, aop, imm;
    if (rs) return 21'd0;
    pcw = (s == 0 && r) || (s == 9 && (z ^ f3[0])) || s == 10;
    adr = (s == 3 || s == 5);
    mr  = (s == 0 || s == 3);
    mw  = (s == 5);
    irw = (s == 0 && r);
    res = (s == 0) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
    sa  = (s == 1 || s == 10) ? 2'd1 : (s == 2 || s == 6 || s == 7 || s == 9) ? 2'd2 : 2'd0;
    sb  = (s == 0 || s == 10) ? 2'd2 : (s == 1 || s == 2 || s == 7) ? 2'd1 : 2'd0;
    aop = (s == 6 || s == 7) ? 2'd2 : (s == 9) ? 2'd1 : 2'd0;
    imm = (op == SW) ? 2'd1 : (op == BR) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
    rw  = (s == 4 || s == 8);
    ill = (s == 15);
    return {pcw, adr, mr, mw, irw, res, sa, sb, aop, imm, rw, ill, 4'(s)};
  endfunction

  logic        chk_en = 1'b0;
  logic [20:0] e_vec;

  always @(negedge clk) begin
    if (chk_en) begin
      e_vec = exp_vec((mq.size() > 0) ? mq[0] : 0, opcode, funct3, zero, mem_ready, rst);
      chk("outputs32", {p_pcw, p_adr, p_mr, p_mw, p_irw, p_rs, p_sa, p_sb, p_aop, p_imm, p_rw, p_ill, p_st}, e_vec);
      chk("outputs4", {q_pcw, q_adr, q_mr, q_mw, q_irw, q_rs, q_sa, q_sb, q_aop, q_imm, q_rw, q_ill, q_st}, e_vec);
      chk("instret32", p_ins, m_instret);
      chk("instret4", q_ins, m_instret[3:0]);
    end
  end

  logic [3:0]  s_state;
  logic        s_pcw, s_rw, s_irw, s_adr, s_mr, s_ill;
  logic [31:0] s_ins;

  // Drive inputs just after a rising edge, snapshot mid-cycle, return just after the next edge.
  task automatic tick(input logic r, input logic z);
    mem_ready = r;
    zero      = z;
    #3;
    s_state = p_st; s_pcw = p_pcw; s_rw = p_rw; s_irw = p_irw;
    s_adr = p_adr; s_mr = p_mr; s_ill = p_ill; s_ins = p_ins;
    @(posedge clk); #1;
  endtask

  task automatic branch_case(input logic [2:0] f3, input logic z, input logic exp_pcw, input string name);
    opcode = BR; funct3 = f3;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, z);
    chk(name, s_pcw, exp_pcw);
  endtask

  logic [35:0] seqv;
  logic [4:0]  rwv;
  logic [3:0]  stallv;
  int          cnt_a, cnt_b, trap_cnt;
  logic [31:0] ins_hold;

  initial begin
    @(posedge clk); #1;
    chk("reset_memread", p_mr, 1'b0);
    chk("reset_irwrite", p_irw, 1'b0);
    chk("reset_state", p_st, 4'd0);
    chk("reset_instret", p_ins, 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    // R-type from reset release
    opcode = RT; funct3 = 3'd0;
    for (int i = 0; i < 5; i++) begin
      tick(i < 4, 1'b0);
      seqv[35-4*i -: 4] = s_state;
      rwv[4-i] = s_rw;
    end
    chk("rtype_states", seqv[35:16], 20'h01680);
    chk("rtype_regwrite", rwv, 5'b00010);
    chk("rtype_instret", s_ins, 32'd1);

    // lw with two FETCH stalls and one MEMREAD stall
    opcode = LW; cnt_a = 0;
    for (int i = 0; i < 9; i++) begin
      tick((i == 0 || i == 1 || i == 5 || i == 8) ? 1'b0 : 1'b1, 1'b0);
      seqv[35-4*i -: 4] = s_state;
      if (s_irw) cnt_a++;
      if (i == 5) stallv[3:2] = {s_adr, s_mr};
      if (i == 6) stallv[1:0] = {s_adr, s_mr};
    end
    chk("lw_states", seqv, 36'h000123340);
    chk("lw_irwrite_pulses", cnt_a, 1);
    chk("lw_stall_requests", stallv, 4'hF);
    chk("lw_instret", s_ins, 32'd2);

    branch_case(3'b000, 1'b1, 1'b1, "beq_zero1");
    branch_case(3'b000, 1'b0, 1'b0, "beq_zero0");
    branch_case(3'b001, 1'b1, 1'b0, "bne_zero1");
    branch_case(3'b001, 1'b0, 1'b1, "bne_zero0");

    // Illegal opcode traps and holds
    opcode = 7'b1111111; funct3 = 3'd0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'($urandom), 1'($urandom));
      if (s_ill) cnt_a++;
      if (s_ins == 32'd6) cnt_b++;
    end
    chk("trap_illegal_cycles", cnt_a, 20);
    chk("trap_instret_frozen", cnt_b, 20);
    rst = 1'b1;
    tick(1'b1, 1'b0);
    chk("trap_reset_state", {s_state, s_ill}, 5'd0);
    rst = 1'b0;

    // Branch with unsupported funct3 traps
    opcode = BR; funct3 = 3'b100;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("bad_branch_trap", s_state, 4'd15);
    rst = 1'b1;
    tick(1'b1, 1'b0);
    rst = 1'b0;

    // Reset during a stalled store
    opcode = RT; funct3 = 3'd0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    opcode = SW;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    mem_ready = 1'b0;
    #2;
    chk("sw_memwrite_before_rst", p_mw, 1'b1);
    rst = 1'b1;
    #1;
    chk("sw_memwrite_async_drop", {p_mw, p_st}, 5'd0);
    @(posedge clk); #1;
    chk("sw_rst_instret", p_ins, 32'd0);
    rst = 1'b0;
    tick(1'b0, 1'b0);
    chk("sw_after_rst_fetch", s_state, 4'd0);

    // 17 back-to-back jal on both counter widths
    opcode = JL; cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      if (s_state == 4'd10 && s_pcw) cnt_a++;
      tick(1'b1, 1'b0);
      if (s_state == 4'd8 && s_rw) cnt_b++;
    end
    chk("jal_pcwrite", cnt_a, 17);
    chk("jal_regwrite", cnt_b, 17);
    chk("jal_wrap4", q_ins, 4'd1);
    chk("jal_count32", p_ins, 32'd17);

    // Randomized instruction stream
    trap_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst) rst = 1'b0;
      else if (mq.size() > 0 && mq[0] == 15) begin
        trap_cnt++;
        if (trap_cnt >= 4) begin rst = 1'b1; trap_cnt = 0; end
      end else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if (mq.size() == 0) begin
        case ($urandom_range(0, 7))
          0, 7:    opcode = LW;
          1:       opcode = SW;
          2:       opcode = RT;
          3:       opcode = IT;
          4:       opcode = BR;
          5:       opcode = JL;
          default: opcode = 7'($urandom);
        endcase
        funct3 = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      end
      zero      = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
